// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the MIPS MEM stage:
//   - state_t       : access FSM encoding (IDLE / WAIT)
//   - memwb_t       : contents of the MEM/WB pipeline boundary
//   - MEMWB_BUBBLE  : the all-zero (invalid, no write-back) MEM/WB value
//   - *_DEFAULT     : default ack timeout and wait-counter width
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

  // Default number of cycles to wait for MemAck before abandoning an access.
  localparam int TIMEOUT_DEFAULT = 16;
  // Default wait-counter width; must be able to hold TIMEOUT.
  localparam int CNT_W_DEFAULT   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  write_reg;
  } memwb_t;

  // A bubble carries no write-back side effect.
  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage : mem_access_stage_pkg

// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Request/acknowledge bus between the MEM stage and data memory.
//   MemReq   : request held high until ack or timeout (master -> slave)
//   MemWe    : 1 = store, 0 = load                       (master -> slave)
//   MemAddr  : word-aligned byte address                 (master -> slave)
//   MemWdata : store data                                (master -> slave)
//   MemRdata : load data, valid together with MemAck     (slave -> master)
//   MemAck   : one-cycle completion pulse                (slave -> master)
// -----------------------------------------------------------------------------
interface mem_access_stage_if;

  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;
  logic        MemAck;

  modport master (
    output MemReq,
    output MemWe,
    output MemAddr,
    output MemWdata,
    input  MemRdata,
    input  MemAck
  );

  modport slave (
    input  MemReq,
    input  MemWe,
    input  MemAddr,
    input  MemWdata,
    output MemRdata,
    output MemAck
  );

endinterface : mem_access_stage_if

// File: rtl/mem_access_stage_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting for a memory acknowledge.
//   clk      : clock
//   rst      : synchronous active-high reset (count -> 0)
//   load     : start a new wait; count becomes 1 (first WAIT cycle)
//   inc      : advance the count by one
//   at_limit : count has reached TIMEOUT
// load has priority over inc.
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic at_limit
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(1);
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == CNT_W'(TIMEOUT));

endmodule : mem_wait_timer

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the 5-stage MIPS pipeline, fed by the EX/MEM register.
//   - Resolves the branch (PCSrc / BranchTarget, combinational).
//   - Performs loads/stores over a req/ack bus (mem), stalling upstream while
//     an access is outstanding, with a misalignment check and ack timeout.
//   - Registers results into the MEM/WB boundary.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   *_in                : EX/MEM control and data (held by upstream on Stall)
//   PCSrc, BranchTarget : branch decision and target
//   Stall               : upstream must hold EX/MEM and PC this cycle
//   mem                 : data-memory request/ack bus (master side)
//   *_out               : MEM/WB register contents
//   MemErr              : one-cycle pulse on misaligned access or timeout
// -----------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                      Clk,
  input  logic                      Reset,
  // EX/MEM
  input  logic                      Valid_in,
  input  logic                      RegWrite_in,
  input  logic                      MemtoReg_in,
  input  logic                      Branch_in,
  input  logic                      MemRead_in,
  input  logic                      MemWrite_in,
  input  logic [31:0]               ALUAddResult_in,
  input  logic                      Zero_in,
  input  logic [31:0]               ALUResult_in,
  input  logic [31:0]               WriteData_in,
  input  logic [4:0]                WriteReg_in,
  // Branch resolution and hazard control
  output logic                      PCSrc,
  output logic [31:0]               BranchTarget,
  output logic                      Stall,
  // Data memory
  mem_access_stage_if.master        mem,
  // MEM/WB
  output logic                      Valid_out,
  output logic                      RegWrite_out,
  output logic                      MemtoReg_out,
  output logic [31:0]               ReadData_out,
  output logic [31:0]               ALUResult_out,
  output logic [4:0]                WriteReg_out,
  output logic                      MemErr
);

  state_t state;
  memwb_t memwb;

  logic   acc;         // instruction touches memory
  logic   mis;         // address not word aligned
  logic   start;       // legal access: enter WAIT
  logic   at_limit;
  logic   timer_load;
  logic   timer_inc;

  memwb_t idle_wb;     // MEM/WB value when no access is launched
  memwb_t ack_wb;      // MEM/WB value on acknowledge
  memwb_t timeout_wb;  // MEM/WB value on timeout

  assign acc   = Valid_in & (MemRead_in | MemWrite_in);
  assign mis   = (ALUResult_in[1:0] != 2'b00);
  assign start = acc & ~mis;

  // Branches only resolve in IDLE; while waiting, the EX/MEM slot is held
  // and will be resolved once the stage is free again.
  assign PCSrc        = Valid_in & Branch_in & Zero_in & (state == IDLE);
  assign BranchTarget = ALUAddResult_in;

  // In WAIT the stall drops on the cycle the access ends (ack or timeout),
  // so upstream advances on the same edge that loads MEM/WB.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    Stall = 1'b0;
    case (state)
      IDLE: Stall = start;
      WAIT: Stall = ~mem.MemAck & ~at_limit;
      default: Stall = 1'b0;
    endcase
  end

  assign timer_load = (state == IDLE) & start;
  assign timer_inc  = (state == WAIT) & ~mem.MemAck & ~at_limit;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk      (Clk),
    .rst      (Reset),
    .load     (timer_load),
    .inc      (timer_inc),
    .at_limit (at_limit)
  );

  // Next MEM/WB candidates. The EX/MEM inputs are still the held access
  // instruction while in WAIT, so they can be used directly at completion.
  always_comb begin
    idle_wb            = MEMWB_BUBBLE;
    idle_wb.valid      = Valid_in;
    idle_wb.reg_write  = RegWrite_in & ~(acc & mis);
    idle_wb.mem_to_reg = MemtoReg_in;
    idle_wb.read_data  = '0;
    idle_wb.alu_result = ALUResult_in;
    idle_wb.write_reg  = WriteReg_in;

    ack_wb             = idle_wb;
    ack_wb.valid       = 1'b1;
    ack_wb.reg_write   = RegWrite_in;
    // Stores (including read+write, which is treated as a store) return 0.
    ack_wb.read_data   = mem.MemWe ? 32'h0 : mem.MemRdata;

    timeout_wb           = idle_wb;
    timeout_wb.valid     = 1'b1;
    timeout_wb.reg_write = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      mem.MemReq   <= 1'b0;
      mem.MemWe    <= 1'b0;
      mem.MemAddr  <= '0;
      mem.MemWdata <= '0;
      memwb        <= MEMWB_BUBBLE;
      MemErr       <= 1'b0;
    end else begin
      MemErr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= WAIT;
            mem.MemReq   <= 1'b1;
            mem.MemWe    <= MemWrite_in;
            mem.MemAddr  <= ALUResult_in;
            mem.MemWdata <= WriteData_in;
            memwb        <= MEMWB_BUBBLE;
          end else begin
            memwb  <= idle_wb;
            MemErr <= acc & mis;
          end
        end
        WAIT: begin
          // Ack wins over a simultaneous timeout.
          if (mem.MemAck) begin
            state      <= IDLE;
            mem.MemReq <= 1'b0;
            memwb      <= ack_wb;
          end else if (at_limit) begin
            state      <= IDLE;
            mem.MemReq <= 1'b0;
            memwb      <= timeout_wb;
            MemErr     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Valid_out     = memwb.valid;
  assign RegWrite_out  = memwb.reg_write;
  assign MemtoReg_out  = memwb.mem_to_reg;
  assign ReadData_out  = memwb.read_data;
  assign ALUResult_out = memwb.alu_result;
  assign WriteReg_out  = memwb.write_reg;

endmodule : mem_access_stage

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed self-checking bench for mem_access_stage (TIMEOUT = 16).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2
// time units after the edge.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        Clk;
  logic        Reset;
  logic        Valid_in;
  logic        RegWrite_in;
  logic        MemtoReg_in;
  logic        Branch_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [31:0] ALUAddResult_in;
  logic        Zero_in;
  logic [31:0] ALUResult_in;
  logic [31:0] WriteData_in;
  logic [4:0]  WriteReg_in;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        Stall;
  logic        Valid_out;
  logic        RegWrite_out;
  logic        MemtoReg_out;
  logic [31:0] ReadData_out;
  logic [31:0] ALUResult_out;
  logic [4:0]  WriteReg_out;
  logic        MemErr;

  int tests_run;
  int tests_failed;

  mem_access_stage_if mem_if ();

  mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Valid_in        (Valid_in),
    .RegWrite_in     (RegWrite_in),
    .MemtoReg_in     (MemtoReg_in),
    .Branch_in       (Branch_in),
    .MemRead_in      (MemRead_in),
    .MemWrite_in     (MemWrite_in),
    .ALUAddResult_in (ALUAddResult_in),
    .Zero_in         (Zero_in),
    .ALUResult_in    (ALUResult_in),
    .WriteData_in    (WriteData_in),
    .WriteReg_in     (WriteReg_in),
    .PCSrc           (PCSrc),
    .BranchTarget    (BranchTarget),
    .Stall           (Stall),
    .mem             (mem_if),
    .Valid_out       (Valid_out),
    .RegWrite_out    (RegWrite_out),
    .MemtoReg_out    (MemtoReg_out),
    .ReadData_out    (ReadData_out),
    .ALUResult_out   (ALUResult_out),
    .WriteReg_out    (WriteReg_out),
    .MemErr          (MemErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Valid_in        = 1'b0;
    RegWrite_in     = 1'b0;
    MemtoReg_in     = 1'b0;
    Branch_in       = 1'b0;
    MemRead_in      = 1'b0;
    MemWrite_in     = 1'b0;
    ALUAddResult_in = 32'h0;
    Zero_in         = 1'b0;
    ALUResult_in    = 32'h0;
    WriteData_in    = 32'h0;
    WriteReg_in     = 5'd0;
    mem_if.MemAck   = 1'b0;
    mem_if.MemRdata = 32'h0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
    clear_inputs();
    Valid_in     = 1'b1;
    MemRead_in   = 1'b1;
    MemtoReg_in  = 1'b1;
    RegWrite_in  = 1'b1;
    ALUResult_in = addr;
    WriteReg_in  = rd;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1'b1;
    next_cycle();
    next_cycle();
    tests_run++; if (Valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", Valid_out); end
    tests_run++; if (mem_if.MemReq !== 1'b0) begin tests_failed++; $display("FAIL reset_memreq got %0b want 0", mem_if.MemReq); end
    tests_run++; if (MemErr !== 1'b0 || RegWrite_out !== 1'b0 || MemtoReg_out !== 1'b0 || mem_if.MemWe !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ctrl got err=%0b rw=%0b m2r=%0b we=%0b want 0", MemErr, RegWrite_out, MemtoReg_out, mem_if.MemWe); end
    tests_run++; if (ReadData_out !== 32'h0 || ALUResult_out !== 32'h0 || WriteReg_out !== 5'd0 || mem_if.MemAddr !== 32'h0 || mem_if.MemWdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_data got rd=%h alu=%h wr=%0d addr=%h wd=%h want 0", ReadData_out, ALUResult_out, WriteReg_out, mem_if.MemAddr, mem_if.MemWdata); end
    tests_run++; if (Stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %0b want 0", Stall); end
    Reset = 1'b0;
  endtask

  task automatic test_alu_op();
    clear_inputs();
    Valid_in     = 1'b1;
    RegWrite_in  = 1'b1;
    ALUResult_in = 32'h0000_0040;
    WriteReg_in  = 5'd8;
    #1;
    tests_run++; if (Stall !== 1'b0) begin tests_failed++; $display("FAIL alu_stall got %0b want 0", Stall); end
    next_cycle();
    tests_run++; if (Valid_out !== 1'b1 || RegWrite_out !== 1'b1) begin tests_failed++; $display("FAIL alu_valid got v=%0b rw=%0b want 1 1", Valid_out, RegWrite_out); end
    tests_run++; if (ALUResult_out !== 32'h40 || WriteReg_out !== 5'd8) begin tests_failed++; $display("FAIL alu_data got %h/%0d want 40/8", ALUResult_out, WriteReg_out); end
    tests_run++; if (mem_if.MemReq !== 1'b0 || MemErr !== 1'b0) begin tests_failed++; $display("FAIL alu_noreq got req=%0b err=%0b want 0 0", mem_if.MemReq, MemErr); end
    clear_inputs();
  endtask

  task automatic test_load();
    int stalls = 0;
    drive_load(32'h100, 5'd9);
    // cycle 0 = IDLE; MemReq rises for cycle 1; ack is seen in cycle 4.
    for (int c = 0; c <= 4; c++) begin
      mem_if.MemAck   = (c == 4);
      mem_if.MemRdata = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      if (Stall === 1'b1) stalls++;
      if (c == 1) begin
        tests_run++; if (mem_if.MemReq !== 1'b1 || mem_if.MemWe !== 1'b0 || mem_if.MemAddr !== 32'h100) begin
          tests_failed++; $display("FAIL load_req got req=%0b we=%0b addr=%h want 1 0 100", mem_if.MemReq, mem_if.MemWe, mem_if.MemAddr); end
        tests_run++; if (Valid_out !== 1'b0 || RegWrite_out !== 1'b0) begin
          tests_failed++; $display("FAIL load_bubble got v=%0b rw=%0b want 0 0", Valid_out, RegWrite_out); end
      end
      next_cycle();
    end
    clear_inputs();
    tests_run++; if (stalls != 4) begin tests_failed++; $display("FAIL load_stall_cycles got %0d want 4", stalls); end
    tests_run++; if (ReadData_out !== 32'hDEAD_BEEF || Valid_out !== 1'b1 || MemtoReg_out !== 1'b1) begin
      tests_failed++; $display("FAIL load_result got rd=%h v=%0b m2r=%0b want deadbeef 1 1", ReadData_out, Valid_out, MemtoReg_out); end
    tests_run++; if (RegWrite_out !== 1'b1 || WriteReg_out !== 5'd9 || mem_if.MemReq !== 1'b0) begin
      tests_failed++; $display("FAIL load_done got rw=%0b wr=%0d req=%0b want 1 9 0", RegWrite_out, WriteReg_out, mem_if.MemReq); end
  endtask

  task automatic test_store();
    clear_inputs();
    Valid_in     = 1'b1;
    MemWrite_in  = 1'b1;
    ALUResult_in = 32'h200;
    WriteData_in = 32'h1234_5678;
    for (int c = 0; c <= 2; c++) begin
      mem_if.MemAck   = (c == 2);
      mem_if.MemRdata = 32'hFFFF_FFFF;
      #1;
      if (c == 1) begin
        tests_run++; if (mem_if.MemReq !== 1'b1 || mem_if.MemWe !== 1'b1 || mem_if.MemWdata !== 32'h1234_5678 || mem_if.MemAddr !== 32'h200) begin
          tests_failed++; $display("FAIL store_req got req=%0b we=%0b wd=%h addr=%h want 1 1 12345678 200", mem_if.MemReq, mem_if.MemWe, mem_if.MemWdata, mem_if.MemAddr); end
      end
      next_cycle();
    end
    clear_inputs();
    tests_run++; if (Valid_out !== 1'b1 || ReadData_out !== 32'h0 || mem_if.MemReq !== 1'b0) begin
      tests_failed++; $display("FAIL store_done got v=%0b rd=%h req=%0b want 1 0 0", Valid_out, ReadData_out, mem_if.MemReq); end
  endtask

  task automatic test_branch();
    clear_inputs();
    Valid_in        = 1'b1;
    Branch_in       = 1'b1;
    Zero_in         = 1'b1;
    ALUAddResult_in = 32'h400;
    #1;
    tests_run++; if (PCSrc !== 1'b1 || BranchTarget !== 32'h400) begin tests_failed++; $display("FAIL branch_taken got %0b/%h want 1/400", PCSrc, BranchTarget); end
    Zero_in = 1'b0;
    #1;
    tests_run++; if (PCSrc !== 1'b0) begin tests_failed++; $display("FAIL branch_not_taken got %0b want 0", PCSrc); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_misaligned();
    drive_load(32'h102, 5'd5);
    #1;
    tests_run++; if (Stall !== 1'b0) begin tests_failed++; $display("FAIL mis_stall got %0b want 0", Stall); end
    next_cycle();
    clear_inputs();
    tests_run++; if (mem_if.MemReq !== 1'b0 || MemErr !== 1'b1 || RegWrite_out !== 1'b0 || Valid_out !== 1'b1) begin
      tests_failed++; $display("FAIL mis_err got req=%0b err=%0b rw=%0b v=%0b want 0 1 0 1", mem_if.MemReq, MemErr, RegWrite_out, Valid_out); end
    next_cycle();
    tests_run++; if (MemErr !== 1'b0) begin tests_failed++; $display("FAIL mis_pulse got %0b want 0", MemErr); end
  endtask

  // ack_last: deliver MemAck on the 16th WAIT cycle instead of timing out.
  task automatic test_timeout(input bit ack_last);
    int stalls = 0;
    int req_cycles = 0;
    drive_load(32'h300, 5'd7);
    for (int c = 0; c <= 16; c++) begin
      mem_if.MemAck   = ack_last && (c == 16);
      mem_if.MemRdata = 32'hCAFE_F00D;
      #1;
      if (Stall === 1'b1) stalls++;
      if (mem_if.MemReq === 1'b1) req_cycles++;
      next_cycle();
    end
    clear_inputs();
    #1;
    tests_run++; if (stalls != 16 || req_cycles != 16) begin tests_failed++; $display("FAIL to_cycles[%0d] got stall=%0d req=%0d want 16 16", ack_last, stalls, req_cycles); end
    tests_run++; if (mem_if.MemReq !== 1'b0 || Stall !== 1'b0 || Valid_out !== 1'b1) begin
      tests_failed++; $display("FAIL to_release[%0d] got req=%0b stall=%0b v=%0b want 0 0 1", ack_last, mem_if.MemReq, Stall, Valid_out); end
    if (ack_last) begin
      tests_run++; if (MemErr !== 1'b0 || RegWrite_out !== 1'b1 || ReadData_out !== 32'hCAFE_F00D) begin
        tests_failed++; $display("FAIL to_ack_wins got err=%0b rw=%0b rd=%h want 0 1 cafef00d", MemErr, RegWrite_out, ReadData_out); end
    end else begin
      tests_run++; if (MemErr !== 1'b1 || RegWrite_out !== 1'b0) begin
        tests_failed++; $display("FAIL to_err got err=%0b rw=%0b want 1 0", MemErr, RegWrite_out); end
    end
    next_cycle();
  endtask

  task automatic test_reset_in_wait();
    drive_load(32'h500, 5'd2);
    next_cycle();   // 1st WAIT cycle
    next_cycle();   // 2nd WAIT cycle
    tests_run++; if (mem_if.MemReq !== 1'b1) begin tests_failed++; $display("FAIL rw_pre got req=%0b want 1", mem_if.MemReq); end
    clear_inputs();
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    #1;
    tests_run++; if (mem_if.MemReq !== 1'b0 || Valid_out !== 1'b0 || Stall !== 1'b0) begin
      tests_failed++; $display("FAIL rw_reset got req=%0b v=%0b stall=%0b want 0 0 0", mem_if.MemReq, Valid_out, Stall); end
    mem_if.MemAck   = 1'b1;
    mem_if.MemRdata = 32'h5555_AAAA;
    next_cycle();
    mem_if.MemAck = 1'b0;
    tests_run++; if (Valid_out !== 1'b0 || ReadData_out !== 32'h0 || mem_if.MemReq !== 1'b0 || MemErr !== 1'b0) begin
      tests_failed++; $display("FAIL rw_stray_ack got v=%0b rd=%h req=%0b err=%0b want 0 0 0 0", Valid_out, ReadData_out, mem_if.MemReq, MemErr); end
  endtask

  task automatic test_back_to_back();
    drive_load(32'h600, 5'd3);
    next_cycle();                 // WAIT, cnt = 1
    mem_if.MemAck   = 1'b1;
    mem_if.MemRdata = 32'h1111_1111;
    next_cycle();                 // back in IDLE, first result in MEM/WB
    drive_load(32'h604, 5'd4);
    #1;
    tests_run++; if (ReadData_out !== 32'h1111_1111 || WriteReg_out !== 5'd3) begin
      tests_failed++; $display("FAIL b2b_first got rd=%h wr=%0d want 11111111 3", ReadData_out, WriteReg_out); end
    tests_run++; if (mem_if.MemReq !== 1'b0 || Stall !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_gap got req=%0b stall=%0b want 0 1", mem_if.MemReq, Stall); end
    next_cycle();
    tests_run++; if (mem_if.MemReq !== 1'b1 || mem_if.MemAddr !== 32'h604) begin
      tests_failed++; $display("FAIL b2b_second_req got req=%0b addr=%h want 1 604", mem_if.MemReq, mem_if.MemAddr); end
    mem_if.MemAck   = 1'b1;
    mem_if.MemRdata = 32'h2222_2222;
    next_cycle();
    clear_inputs();
    tests_run++; if (ReadData_out !== 32'h2222_2222 || WriteReg_out !== 5'd4 || Valid_out !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_second got rd=%h wr=%0d v=%0b want 22222222 4 1", ReadData_out, WriteReg_out, Valid_out); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset        = 1'b1;
    clear_inputs();
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_branch();
    test_misaligned();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog: the directed sequence is a few hundred cycles long.
  initial begin
    #50000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule : tb_mem_access_stage

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX stage via the EX/MEM register.
- Resolves the branch decision, performs the load or store against data memory through a req/ack handshake, and stalls upstream while an access is outstanding.
- Registers results into the MEM/WB boundary for the WB stage.

Parameters:
- TIMEOUT, 16, max cycles waiting for MemAck before abandoning the access (must be >=2)
- CNT_W, 5, width of the wait counter (must hold TIMEOUT)

Ports:
- Clk  in  1  pipeline clock
- Reset  in  1  synchronous, active-high reset
- Valid_in  in  1  EX/MEM slot holds a real instruction
- RegWrite_in  in  1  control from EX/MEM
- MemtoReg_in  in  1  control from EX/MEM
- Branch_in  in  1  control from EX/MEM
- MemRead_in  in  1  control from EX/MEM
- MemWrite_in  in  1  control from EX/MEM
- ALUAddResult_in  in  32  branch target from EX
- Zero_in  in  1  ALU zero flag
- ALUResult_in  in  32  ALU result / memory byte address
- WriteData_in  in  32  store data (rt value)
- WriteReg_in  in  5  destination register (RegDst mux result)
- PCSrc  out  1  take branch
- BranchTarget  out  32  next PC when PCSrc=1
- Stall  out  1  upstream must hold EX/MEM and PC this cycle
- MemReq  out  1  data-memory request
- MemWe  out  1  1=store, 0=load
- MemAddr  out  32  word-aligned byte address
- MemWdata  out  32  store data
- MemRdata  in  32  load data, valid with MemAck
- MemAck  in  1  one-cycle completion pulse
- Valid_out  out  1  MEM/WB slot valid
- RegWrite_out  out  1  MEM/WB control
- MemtoReg_out  out  1  MEM/WB control
- ReadData_out  out  32  captured load data
- ALUResult_out  out  32  passed ALU result
- WriteReg_out  out  5  passed destination
- MemErr  out  1  one-cycle pulse on misaligned address or timeout

Behaviour:
- Reset: state IDLE; counter 0; MemReq, MemWe, MemErr, Valid_out, RegWrite_out, MemtoReg_out = 0; MemAddr, MemWdata, ReadData_out, ALUResult_out = 0; WriteReg_out = 0.
- Definitions:
  - acc = Valid_in & (MemRead_in | MemWrite_in)
  - mis = ALUResult_in[1:0] != 0
  - If MemRead_in and MemWrite_in are both set, treat the instruction as a store.
- PCSrc = Valid_in & Branch_in & Zero_in & (state==IDLE), combinational. BranchTarget = ALUAddResult_in.
- IDLE, no acc, or acc with mis:
  - Stall = 0.
  - Next edge: load MEM/WB from the inputs. Valid_out = Valid_in; ReadData_out = 0.
  - If mis: RegWrite_out forced 0 and MemErr pulses 1 cycle.
  - Latency: 1 cycle.
- IDLE, acc and not mis:
  - Stall = 1.
  - Next edge: go to WAIT. Register MemReq=1, MemWe=MemWrite_in, MemAddr=ALUResult_in, MemWdata=WriteData_in; counter=1.
  - Load a bubble into MEM/WB: Valid_out=0, RegWrite_out=0.
- WAIT:
  - MemReq, MemWe, MemAddr and MemWdata are held stable.
  - Stall = ~MemAck & (counter != TIMEOUT).
  - On MemAck:
    - Next edge: go to IDLE, MemReq=0, Valid_out=1, ReadData_out=MemRdata for loads, else 0.
    - RegWrite_out, MemtoReg_out, ALUResult_out and WriteReg_out come from the held inputs.
    - Minimum access latency: 2 cycles from entry into IDLE.
  - counter==TIMEOUT without MemAck:
    - Next edge: go to IDLE, MemReq=0, Valid_out=1, RegWrite_out=0, MemErr pulses.
  - MemAck on the same cycle as counter==TIMEOUT: the ack wins.
  - Otherwise: counter increments.
- The EX/MEM inputs are stable while Stall=1, because upstream holds them. The block does not re-latch them.
- MemAck while in IDLE is ignored.
- Reset during WAIT: at the next edge MemReq drops, and all outputs take their reset values. No ack is awaited.
- Back-to-back accesses: after an ack the next edge returns to IDLE. A new access on the following instruction re-enters WAIT, so there is at least one cycle with MemReq=0 between requests.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, WAIT=1'b1), the MEM/WB bubble constant, and the TIMEOUT default.
- One natural sub-module, mem_wait_timer: the counter with load, increment and ==TIMEOUT compare.
- The FSM and the MEM/WB register stay in the top module.

Test Plan:
- Valid_in=1, ALU op (no mem), ALUResult_in=32'h0000_0040, WriteReg_in=5'd8, RegWrite_in=1 -> next cycle Valid_out=1, ALUResult_out=0x40, WriteReg_out=8, Stall=0, MemReq never asserted.
- Load: ALUResult_in=0x100, memory acks 3 cycles after MemReq rises with MemRdata=0xDEADBEEF -> Stall high for 4 cycles, MemAddr=0x100, MemWe=0. Then ReadData_out=0xDEADBEEF, Valid_out=1, MemtoReg_out=1.
- Store: WriteData_in=0x12345678 at address 0x200, ack after 1 cycle -> MemWe=1, MemWdata=0x12345678, Valid_out=1, ReadData_out=0.
- Branch: Branch_in=1, Zero_in=1, ALUAddResult_in=0x400 -> PCSrc=1 and BranchTarget=0x400 in the same cycle. With Zero_in=0 -> PCSrc=0.
- Misaligned load at 0x102 -> no MemReq, MemErr pulses once, RegWrite_out=0. Separately: no ack for TIMEOUT=16 cycles -> MemReq drops, MemErr pulses, Stall released. Ack arriving on cycle 16 -> normal completion.
- Reset asserted on the 2nd WAIT cycle -> next edge MemReq=0, Valid_out=0, Stall=0. A later MemAck is ignored.
